// File: rtl/fmap_collect_if.sv
// Feature-map collector bus: pooled-word input stream, valid/ready read port,
// and per-frame statistics.
interface fmap_collect_if #(
   parameter int DATA_W = 22
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              out_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic [3:0]        out_row;
   logic [3:0]        out_col;
   logic              out_last;
   logic              frame_done;
   logic [DATA_W-1:0] frame_max;
   logic [7:0]        frame_max_idx;
   logic [7:0]        drop_cnt;
   logic              overflow;

   modport master (
      output in_valid, in_data, out_ready,
      input  out_valid, out_data, out_row, out_col, out_last,
      input  frame_done, frame_max, frame_max_idx, drop_cnt, overflow
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output out_valid, out_data, out_row, out_col, out_last,
      output frame_done, frame_max, frame_max_idx, drop_cnt, overflow
   );
endinterface

// File: rtl/fmap_collect.sv
// fmap_collect: captures one pooled feature map into a register buffer, then
// replays it in raster order over a valid/ready port with per-frame max/index
// and drop statistics. All outputs are registered.
module fmap_collect #(
   parameter int DATA_W = 22,
   parameter int MAP_W  = 14,
   parameter int MAP_H  = 14
) (
   input logic            clk,
   input logic            rstn,
   fmap_collect_if.slave  io
);
   localparam int         MAP_N    = MAP_H * MAP_W;
   localparam logic [7:0] LAST_IDX = 8'(MAP_N - 1);
   localparam logic [3:0] LAST_COL = 4'(MAP_W - 1);

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_LOAD = 2'd1,
      ST_READ = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [DATA_W-1:0] r_mem [0:MAP_N-1];
   logic [7:0]        r_wr_ptr;
   logic [7:0]        r_rd_ptr;
   logic [3:0]        r_row;
   logic [3:0]        r_col;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_last;
   logic              r_frame_done;
   logic [DATA_W-1:0] r_frame_max;
   logic [7:0]        r_frame_max_idx;
   logic [DATA_W-1:0] r_run_max;
   logic [7:0]        r_run_idx;
   logic [7:0]        r_drop_cnt;
   logic              r_overflow;

   logic              w_wr_en;
   logic              w_last_wr;
   logic              w_drop;
   logic              w_load;
   logic              w_hs;
   logic              w_last_rd;
   logic              w_max_upd;
   logic [DATA_W-1:0] w_fin_max;
   logic [7:0]        w_fin_idx;
   logic [7:0]        w_rd_nxt;

   assign w_rd_nxt = r_rd_ptr + 8'd1;

   // Next-state decode and per-cycle control strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_wr_en     = 1'b0;
      w_last_wr   = 1'b0;
      w_drop      = 1'b0;
      w_load      = 1'b0;
      w_hs        = 1'b0;
      w_last_rd   = 1'b0;
      case (r_state)
         ST_FILL: begin
            if (io.in_valid) begin
               w_wr_en = 1'b1;
               if (r_wr_ptr == LAST_IDX) begin
                  w_last_wr   = 1'b1;
                  w_state_nxt = ST_LOAD;
               end else begin
                  w_state_nxt = ST_FILL;
               end
            end else begin
               w_state_nxt = ST_FILL;
            end
         end
         ST_LOAD: begin
            w_load      = 1'b1;
            w_drop      = io.in_valid;
            w_state_nxt = ST_READ;
         end
         ST_READ: begin
            // Strobes arriving while the map is being read out are discarded,
            // including one coincident with the final handshake.
            w_drop = io.in_valid;
            if (io.out_ready) begin
               w_hs = 1'b1;
               if (r_rd_ptr == LAST_IDX) begin
                  w_last_rd   = 1'b1;
                  w_state_nxt = ST_FILL;
               end else begin
                  w_state_nxt = ST_READ;
               end
            end else begin
               w_state_nxt = ST_READ;
            end
         end
         default: begin
            w_state_nxt = ST_FILL;
         end
      endcase
   end

   // Running max candidate: first word of a frame always seeds it; afterwards
   // only a strictly greater signed value wins, so ties keep the earliest index.
   always_comb begin
      w_max_upd = (r_wr_ptr == 8'd0) || ($signed(io.in_data) > $signed(r_run_max));
      if (w_max_upd) begin
         w_fin_max = io.in_data;
         w_fin_idx = r_wr_ptr;
      end else begin
         w_fin_max = r_run_max;
         w_fin_idx = r_run_idx;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_FILL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Map storage: not reset, combinational read through the pointer mux below.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= io.in_data;
      end
   end

   // Fill side: write pointer, running max and frame statistics.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr        <= 8'd0;
         r_run_max       <= '0;
         r_run_idx       <= 8'd0;
         r_frame_done    <= 1'b0;
         r_frame_max     <= '0;
         r_frame_max_idx <= 8'd0;
      end else begin
         r_frame_done <= w_last_wr;
         if (w_wr_en) begin
            r_run_max <= w_fin_max;
            r_run_idx <= w_fin_idx;
            if (!w_last_wr) begin
               r_wr_ptr <= r_wr_ptr + 8'd1;
            end
         end
         // Statistics become visible together with frame_done and hold until
         // the next completed frame.
         if (w_last_wr) begin
            r_frame_max     <= w_fin_max;
            r_frame_max_idx <= w_fin_idx;
         end
         if (w_last_rd) begin
            r_wr_ptr  <= 8'd0;
            r_run_max <= '0;
            r_run_idx <= 8'd0;
         end
      end
   end

   // Read side: read pointer, row/column counters and the registered word.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rd_ptr    <= 8'd0;
         r_row       <= 4'd0;
         r_col       <= 4'd0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
      end else if (w_load) begin
         r_rd_ptr    <= 8'd0;
         r_row       <= 4'd0;
         r_col       <= 4'd0;
         r_out_valid <= 1'b1;
         r_out_data  <= r_mem[0];
         r_out_last  <= (LAST_IDX == 8'd0);
      end else if (w_last_rd) begin
         r_rd_ptr    <= 8'd0;
         r_row       <= 4'd0;
         r_col       <= 4'd0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end else if (w_hs) begin
         r_rd_ptr   <= w_rd_nxt;
         r_out_data <= r_mem[w_rd_nxt];
         r_out_last <= (w_rd_nxt == LAST_IDX);
         if (r_col == LAST_COL) begin
            r_col <= 4'd0;
            r_row <= r_row + 4'd1;
         end else begin
            r_col <= r_col + 4'd1;
         end
      end
   end

   // Drop statistics: saturating count and sticky flag, cleared only by reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_drop_cnt <= 8'd0;
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (r_drop_cnt != 8'hFF) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
         end
      end
   end

   assign io.out_valid     = r_out_valid;
   assign io.out_data      = r_out_data;
   assign io.out_row       = r_row;
   assign io.out_col       = r_col;
   assign io.out_last      = r_out_last;
   assign io.frame_done    = r_frame_done;
   assign io.frame_max     = r_frame_max;
   assign io.frame_max_idx = r_frame_max_idx;
   assign io.drop_cnt      = r_drop_cnt;
   assign io.overflow      = r_overflow;
endmodule

// File: tb/tb_fmap_collect.sv
// Directed bench for fmap_collect: fills, readouts (plain and stalled), drop
// counting/saturation and mid-fill reset, checked with immediate assertions.
module tb_fmap_collect;
   localparam int DW = 22;
   localparam int N  = 196;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   fd_cnt = 0;
   logic [DW-1:0] frm [N];

   always #5 clk = ~clk;

   fmap_collect_if #(.DATA_W(DW)) bus ();

   fmap_collect #(.DATA_W(DW), .MAP_W(14), .MAP_H(14)) u_dut (
      .clk  (clk),
      .rstn (rstn),
      .io   (bus)
   );

   // Count frame_done pulses away from the active edge.
   always @(negedge clk) begin
      if (bus.frame_done === 1'b1) fd_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fill_frame(input int n);
      for (int i = 0; i < n; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = frm[i];
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
   endtask

   // Called in the LOAD cycle right after the final write; leaves the bench in
   // the first READ cycle.
   task automatic post_fill(input logic [DW-1:0] exp_max, input logic [7:0] exp_idx);
      chk("load_done",  32'(bus.frame_done), 32'd1);
      chk("load_valid", 32'(bus.out_valid), 32'd0);
      chk("frame_max",  32'(bus.frame_max), 32'(exp_max));
      chk("frame_idx",  32'(bus.frame_max_idx), 32'(exp_idx));
      @(posedge clk); #1;
      chk("done_pulse", 32'(bus.frame_done), 32'd0);
   endtask

   task automatic read_frame(input bit stall, input int drops);
      int   k;
      int   cyc;
      logic rdy;
      k   = 0;
      cyc = 0;
      while (k < N && cyc < 3000) begin
         if (stall) rdy = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         else       rdy = 1'b1;
         bus.out_ready = rdy;
         bus.in_valid  = (cyc < drops);
         bus.in_data   = 22'h155;
         chk("rd_valid", 32'(bus.out_valid), 32'd1);
         chk("rd_data",  32'(bus.out_data), 32'(frm[k]));
         chk("rd_row",   32'(bus.out_row), 32'(k / 14));
         chk("rd_col",   32'(bus.out_col), 32'(k % 14));
         chk("rd_last",  32'(bus.out_last), (k == N - 1) ? 32'd1 : 32'd0);
         @(posedge clk); #1;
         if (rdy) k++;
         cyc++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk("rd_handshakes", 32'(k), 32'(N));
      chk("rd_valid_off",  32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      // Reset state.
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_data",  32'(bus.out_data), 32'd0);
      chk("rst_row",   32'(bus.out_row), 32'd0);
      chk("rst_col",   32'(bus.out_col), 32'd0);
      chk("rst_last",  32'(bus.out_last), 32'd0);
      chk("rst_done",  32'(bus.frame_done), 32'd0);
      chk("rst_max",   32'(bus.frame_max), 32'd0);
      chk("rst_idx",   32'(bus.frame_max_idx), 32'd0);
      chk("rst_drop",  32'(bus.drop_cnt), 32'd0);
      chk("rst_ovf",   32'(bus.overflow), 32'd0);
      rstn = 1'b1;
      @(posedge clk); #1;

      // Frame A: value i at index i, unstalled readout with 5 drops in READ.
      for (int i = 0; i < N; i++) frm[i] = 22'(i);
      fill_frame(N);
      post_fill(22'd195, 8'd195);
      read_frame(1'b0, 5);
      chk("fd_once_a", 32'(fd_cnt), 32'd1);
      chk("drop_5",    32'(bus.drop_cnt), 32'd5);
      chk("ovf_set",   32'(bus.overflow), 32'd1);

      // Frame B: zeros, -3 at 0, 500 at 37 and 120 -> earliest tie kept.
      for (int i = 0; i < N; i++) frm[i] = 22'd0;
      frm[0]   = 22'h3FFFFD;
      frm[37]  = 22'd500;
      frm[120] = 22'd500;
      fill_frame(N);
      post_fill(22'd500, 8'd37);
      read_frame(1'b0, 0);
      chk("fd_once_b",  32'(fd_cnt), 32'd2);
      chk("drop_stays", 32'(bus.drop_cnt), 32'd5);

      // Frame A again, read out with out_ready toggling.
      for (int i = 0; i < N; i++) frm[i] = 22'(i);
      fill_frame(N);
      post_fill(22'd195, 8'd195);
      read_frame(1'b1, 0);
      chk("fd_once_s", 32'(fd_cnt), 32'd3);

      // Saturation: 300 strobes while READ is stalled.
      fill_frame(N);
      post_fill(22'd195, 8'd195);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 22'h2AA;
      repeat (300) begin
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      chk("drop_sat",    32'(bus.drop_cnt), 32'd255);
      chk("sat_ovf",     32'(bus.overflow), 32'd1);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_data",  32'(bus.out_data), 32'd0);
      read_frame(1'b0, 0);

      // Mid-fill reset: 100 words, reset, then a full frame with negatives.
      for (int i = 0; i < N; i++) frm[i] = 22'(1000 - 10 * i);
      fill_frame(100);
      chk("part_nodone", 32'(bus.frame_done), 32'd0);
      rstn = 1'b0;
      #2;
      chk("arst_drop",  32'(bus.drop_cnt), 32'd0);
      chk("arst_ovf",   32'(bus.overflow), 32'd0);
      chk("arst_max",   32'(bus.frame_max), 32'd0);
      chk("arst_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_data",  32'(bus.out_data), 32'd0);
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;
      chk("part_no_fd", 32'(fd_cnt), 32'd4);
      fill_frame(N);
      post_fill(22'd1000, 8'd0);
      read_frame(1'b0, 0);
      chk("fd_after_rst",   32'(fd_cnt), 32'd5);
      chk("drop_after_rst", 32'(bus.drop_cnt), 32'd0);
      chk("ovf_after_rst",  32'(bus.overflow), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
